// File: rtl/gf_inv.sv
// Sequential GF(2^8) inverter: computes a^254 by square-and-multiply
// on a single MSB-first bit-serial multiplier (0 maps to 0).
module gf_inv #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_state,
  output logic [7:0] o_state,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     r_fsm;
  logic [7:0] r_a;
  logic [7:0] r_x;
  logic [7:0] r_m;
  logic [7:0] r_n;
  logic [7:0] r_acc;
  logic [3:0] r_op;
  logic [2:0] r_bit;

  logic [7:0] w_xt;
  logic [7:0] w_acc_nxt;

  always_comb begin
    w_xt      = {r_acc[6:0], 1'b0} ^ (r_acc[7] ? POLY[7:0] : '0);
    w_acc_nxt = w_xt ^ (r_n[r_bit] ? r_m : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_a     <= '0;
      r_x     <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_acc   <= '0;
      r_op    <= '0;
      r_bit   <= '0;
      o_state <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (i_start) begin
            r_a    <= i_state;
            r_x    <= i_state;
            r_m    <= i_state;
            r_n    <= i_state;
            r_acc  <= '0;
            r_op   <= '0;
            r_bit  <= 3'd7;
            o_busy <= 1'b1;
            r_fsm  <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_bit == 3'd0) begin
            r_x   <= w_acc_nxt;
            r_acc <= '0;
            r_bit <= 3'd7;
            r_op  <= r_op + 4'd1;
            // Latch the next op's operands from the freshly produced x:
            // an even current op is followed by a multiply by a.
            r_m   <= w_acc_nxt;
            r_n   <= r_op[0] ? w_acc_nxt : r_a;
            if (r_op == 4'd12) begin
              o_state <= w_acc_nxt;
              o_done  <= 1'b1;
              r_fsm   <= S_DONE;
            end
          end else begin
            r_acc <= w_acc_nxt;
            r_bit <= r_bit - 3'd1;
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          r_fsm  <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_inv.sv
// Scoreboard bench for gf_inv: driver pushes expected results and accept
// cycles, a negedge monitor pops and checks on every o_done pulse.
module tb_gf_inv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_state = '0;
  logic [7:0] o_state;
  logic       o_busy;
  logic       o_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] exp;
    int         acc_cyc;
  } sb_t;
  sb_t sb[$];

  gf_inv #(.POLY(9'h11B)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_state(i_state),
    .o_state(o_state), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    logic [7:0] r = '0;
    for (int c = 1; c < 256; c++)
      if (gf_mul(a, 8'(c)) == 8'h01) r = 8'(c);
    return r;
  endfunction

  // Monitor
  logic       prev_done = 1'b0;
  logic [7:0] prev_state = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_done  = 1'b0;
      prev_state = o_state;
    end else begin
      if (o_done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_pulse: o_done high two cycles at cyc %0d", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: o_done with o_state=%h, nothing expected", o_state);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (o_state !== e.exp) begin
            errors++;
            $display("FAIL result: got %h expected %h", o_state, e.exp);
          end
          checks++;
          if (cyc - e.acc_cyc != 104) begin
            errors++;
            $display("FAIL latency: got %0d expected 104", cyc - e.acc_cyc);
          end
        end
      end else if (o_busy) begin
        checks++;
        if (o_state !== prev_state) begin
          errors++;
          $display("FAIL hold: o_state changed to %h from %h during run", o_state, prev_state);
        end
      end
      prev_done  = o_done;
      prev_state = o_state;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_busy) begin
      errors++;
      $display("FAIL timeout: o_busy stuck high, got 1 expected 0");
    end
  endtask

  task automatic start_op(input logic [7:0] v, input logic [7:0] exp, input bit hold);
    wait_idle();
    i_start = 1'b1;
    i_state = v;
    @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL accept: o_busy=%b expected 1 for operand %h", o_busy, v);
    end else begin
      sb.push_back('{exp: exp, acc_cyc: cyc});
    end
    if (!hold) i_start = 1'b0;
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (o_state !== 8'h00 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: state=%h busy=%b done=%b expected 00/0/0", name, o_state, o_busy, o_done);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_cleared("reset_state");
    rst = 1'b0;

    // Directed vectors
    start_op(8'h53, 8'hCA, 0);
    wait_idle();
    repeat (2) @(negedge clk);
    // Asynchronous reset while idle, observed before the next clock edge
    rst = 1'b1;
    #1;
    check_cleared("async_rst_idle");
    @(negedge clk);
    rst = 1'b0;

    start_op(8'h02, 8'h8D, 0);
    start_op(8'h01, 8'h01, 0);
    start_op(8'hFF, 8'h1C, 0);
    start_op(8'h00, 8'h00, 0);

    // i_start pulse mid-run must be ignored
    start_op(8'h53, 8'hCA, 0);
    repeat (49) @(negedge clk);
    i_start = 1'b1;
    i_state = 8'h02;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle();
    repeat (120) @(negedge clk);

    // Reset mid-run aborts with no o_done
    start_op(8'h53, 8'hCA, 0);
    repeat (59) @(negedge clk);
    rst = 1'b1;
    #1;
    check_cleared("rst_mid_run");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    start_op(8'h02, 8'h8D, 0);

    // i_start held high: back-to-back conversions
    start_op(8'h03, 8'hF6, 1);
    start_op(8'h53, 8'hCA, 1);
    start_op(8'h02, 8'h8D, 0);

    // All nonzero operands against a reference multiplier
    for (int a = 1; a < 256; a++)
      start_op(8'(a), ref_inv(8'(a)), (a % 3) != 0);
    i_start = 1'b0;

    wait_idle();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_done: %0d results outstanding, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
